// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Funct7 that marks an R-type instruction as an M-extension op.
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the decoder/execute stage and the sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is the only backpressure; the requester holds while it is high.
// master: drives start/flush/funct3/op_a/op_b, observes busy/stall/done/result.
// slave : the sequencer side, directions reversed.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand/accumulator/remainder registers and one radix-2 mul/div step per strobe.
// Latency: load 1 cycle, WIDTH step strobes, fix 1 cycle; fast-path result written on load.
// Backpressure: none; purely strobe driven by the sequencer FSM.
// Ports: load/step/fix strobes, funct3 + operands (sampled on load), fast (comb flag), result.
module muldiv_datapath import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fast,
    output logic [WIDTH-1:0] result
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2:0]         f3_q, f3_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;       // product, or quotient in the low half
    logic [WIDTH:0]     rem_q, rem_d;       // partial remainder
    logic               neg_q, neg_d;       // product/quotient sign
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_signed, b_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b, fast_res;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   shifted, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // Acceptance-time operand conditioning and fast-path detection.
    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sign_a   = a_signed & op_a[WIDTH-1];
        sign_b   = b_signed & op_b[WIDTH-1];
        abs_a    = sign_a ? (~op_a + WIDTH'(1)) : op_a;
        abs_b    = sign_b ? (~op_b + WIDTH'(1)) : op_b;
        div_zero = is_div_op(funct3) && (op_b == '0);
        div_ovf  = is_div_op(funct3) && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        fast     = div_zero | div_ovf;
        // funct3[1] picks REM/REMU over DIV/DIVU.
        if (div_zero) fast_res = funct3[1] ? op_a : '1;
        else          fast_res = funct3[1] ? '0 : op_a;
    end

    // One radix-2 step: add-shift for multiply, restoring shift-subtract for divide.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {rem_q, acc_q[WIDTH-1]};
        diff    = shifted - {2'b00, opnd_q};
    end

    // Sign restoration for FIX.
    always_comb begin
        prod = neg_q     ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quo  = neg_q     ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem  = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
    end

    always_comb begin
        f3_d      = f3_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (load) begin
            f3_d      = funct3;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            rem_d     = '0;
            if (is_div_op(funct3)) begin
                opnd_d = abs_b;
                acc_d  = {{WIDTH{1'b0}}, abs_a};
            end else begin
                opnd_d = abs_a;
                acc_d  = {{WIDTH{1'b0}}, abs_b};
            end
            if (fast) result_d = fast_res;
        end else if (step) begin
            if (is_div_op(f3_q)) begin
                // diff[WIDTH+1] is the borrow; no borrow means the quotient bit is 1.
                rem_d = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH+1]};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end else if (fix) begin
            case (f3_q)
                F3_MUL:                      result_d = prod[WIDTH-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod[2*WIDTH-1:WIDTH];
                F3_DIV, F3_DIVU:             result_d = quo;
                default:                     result_d = rem;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f3_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            f3_q      <= f3_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: FSM + iteration counter around muldiv_datapath.
// Latency: WIDTH+2 cycles accept-to-done, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall holds upstream while busy or while a start is being accepted; start in CALC/FIX is dropped.
// Ports: clk, reset (async active-low), bus (slave modport: start/flush/funct3/op_a/op_b in, busy/stall/done/result out).
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic idle_or_done, accept, fast;
    logic busy, done, step, fix;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign accept       = idle_or_done && bus.start && !bus.flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = fast ? DONE : CALC;
                        cnt_d   = CW'(WIDTH-1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = FIX;
                end
                FIX:     state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are gated by flush so an aborted op never writes result.
    always_comb begin
        busy = (state_q == CALC) || (state_q == FIX);
        done = (state_q == DONE);
        step = (state_q == CALC) && !bus.flush;
        fix  = (state_q == FIX)  && !bus.flush;
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.stall = busy | accept;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (step),
        .fix    (fix),
        .funct3 (bus.funct3),
        .op_a   (bus.op_a),
        .op_b   (bus.op_b),
        .fast   (fast),
        .result (bus.result)
    );

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations, i.e. the R-type encodings with Funct7 = 0000001 that the single-cycle ALU does not execute.
- Sits in the execute stage beside the ALU. The main decoder raises start with the operands and Funct3. The block then holds the pipeline via stall while an iterative shift-add multiplier or restoring divider runs, and returns a registered result with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- flush  input  1  abort current operation (branch mispredict/trap).
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value (multiplicand/dividend).
- op_b  input  WIDTH  rs2 value (multiplier/divisor).
- busy  output  1  high in CALC and FIX.
- stall  output  1  combinational: busy | (start & ~flush & state==IDLE|DONE); freezes upstream stages.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  WIDTH  registered result; holds its value until the next accepted start.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - busy, done, result, the iteration counter and all internal registers go to 0.
  - An operation in progress at reset is lost; no done is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- Start acceptance, from IDLE or DONE with start=1 and flush=0:
  - Latch funct3.
  - Latch the absolute values of the operands where the op is signed:
    - MULH: both operands.
    - MULHSU: op_a only.
    - DIV/REM: both operands.
  - Latch the result-sign flags:
    - Quotient/product sign = sign_a XOR sign_b.
    - Remainder sign = sign_a.
  - Load counter = WIDTH-1, then go to CALC.
- Fast path, checked at acceptance; go directly to DONE, so done appears on the next cycle:
  - Divide by zero (op_b==0):
    - DIV/DIVU give all-ones.
    - REM/REMU give op_a.
  - Signed overflow (DIV/REM with op_a = 1 followed by zeros, op_b = all-ones):
    - DIV gives op_a.
    - REM gives 0.
- CALC: one radix-2 step per cycle; the counter decrements and the state leaves to FIX after the step with counter==0 (exactly WIDTH cycles).
  - Multiply: 2*WIDTH-bit product accumulator, add-shift on multiplier LSB.
  - Divide: restoring shift-subtract; quotient bit = no-borrow.
- FIX: one cycle. Apply two's-complement negation per the sign flags, select the output, and write result:
  - MUL: low word of the product.
  - MULH/MULHSU/MULHU: high word of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: done=1 for exactly one cycle.
  - Next state is CALC (or DONE again via the fast path) if a new start is accepted, else IDLE.
- Latency, start-accept edge to done: WIDTH+2 cycles normal (34 at WIDTH=32); 1 cycle fast path.
- Start while busy (CALC/FIX): ignored, no queueing.
- flush: from any state, the next state is IDLE.
  - done is not asserted; result is unchanged.
  - flush has priority over a simultaneous start.
  - flush in DONE suppresses nothing, because done is already visible.
- Arithmetic widths:
  - Product accumulator is 2*WIDTH bits.
  - Partial remainder is WIDTH+1 bits.
  - All sign handling is done only at acceptance and in FIX.

Decomposition:
- muldiv_pkg holds:
  - The state_t enum (IDLE, CALC, FIX, DONE).
  - localparams for the eight funct3 codes.
  - FUNCT7_MULDIV = 7'b0000001, used by the decoder.
- One sub-module, muldiv_datapath:
  - Owns the operand, accumulator and remainder registers and the per-cycle step logic.
  - Takes load/step/fix strobes from the FSM in muldiv_sequencer.
  - FSM and counter stay in the top module.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 34 cycles after the accept edge; busy and stall high throughout; start pulsed mid-run is ignored.
2. Multiply-high variants:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide/remainder:
   - DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD.
   - REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14.
   - REMU 100/7 -> 2.
4. Fast path, done one cycle after accept in each case:
   - DIV 5/0 -> 0xFFFFFFFF.
   - REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM of the same operands -> 0.
5. Flush and restart: flush asserted on the 10th CALC cycle together with start -> IDLE next cycle, no done, result unchanged; a subsequent MUL 3*4 -> 12 at normal latency.
6. Back-to-back and reset:
   - Back-to-back: start asserted in the DONE cycle with DIVU 9/3 -> accepted, done again 34 cycles later with 3.
   - Reset: reset driven low mid-CALC -> busy/done/result 0 immediately; no done after release.
